uop_dispatch_queue: RTL and testbench

//  Registered, parametrised successor to the combinational opcode-to-microcode mapper.

---
 rtl/uop_dispatch_queue.sv | 149 ++++++++++++++
 tb/tb_uop_dispatch_queue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uop_dispatch_queue.sv
// rtl/uop_dispatch_queue.sv - RV32I/M decode into a microcode-address dispatch FIFO
module uop_dispatch_queue #(
  parameter int ADDR_W  = 6,
  parameter int MEXT_EN = 1,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [31:0]                out_instr,
  output logic                       out_illegal,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNT_W-1:0]           illegal_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ILLEGAL_ADDR = {ADDR_W{1'b1}};

  logic [6:0]        w_op;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [ADDR_W-1:0] w_dec_addr;
  logic              w_dec_illegal;
  logic              w_push;
  logic              w_pop;

  logic [ADDR_W-1:0] r_mem_addr  [DEPTH];
  logic [31:0]       r_mem_instr [DEPTH];
  logic              r_mem_ill   [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [OCC_W-1:0]  r_occ;
  logic [CNT_W-1:0]  r_cnt;

  assign w_op = in_instr[6:0];
  assign w_f3 = in_instr[14:12];
  assign w_f7 = in_instr[31:25];

  // Instruction decode: map opcode/funct fields to a microcode start address.
  always_comb begin
    w_dec_addr = ILLEGAL_ADDR;
    unique case (w_op)
      7'b0110011: begin
        if (w_f7 == 7'b0000000) begin
          unique case (w_f3)
            3'b000: w_dec_addr = ADDR_W'(1);
            3'b001: w_dec_addr = ADDR_W'(6);
            3'b010: w_dec_addr = ADDR_W'(9);
            3'b011: w_dec_addr = ADDR_W'(10);
            3'b100: w_dec_addr = ADDR_W'(5);
            3'b101: w_dec_addr = ADDR_W'(7);
            3'b110: w_dec_addr = ADDR_W'(4);
            default: w_dec_addr = ADDR_W'(3);
          endcase
        end else if (w_f7 == 7'b0100000) begin
          if (w_f3 == 3'b000)      w_dec_addr = ADDR_W'(2);
          else if (w_f3 == 3'b101) w_dec_addr = ADDR_W'(8);
        end else if (w_f7 == 7'b0000001 && MEXT_EN != 0) begin
          unique case (w_f3)
            3'b000: w_dec_addr = ADDR_W'(27);
            3'b001: w_dec_addr = ADDR_W'(30);
            3'b010: w_dec_addr = ADDR_W'(31);
            3'b011: w_dec_addr = ADDR_W'(32);
            3'b100: w_dec_addr = ADDR_W'(28);
            3'b101: w_dec_addr = ADDR_W'(33);
            3'b110: w_dec_addr = ADDR_W'(29);
            default: w_dec_addr = ADDR_W'(34);
          endcase
        end
      end
      7'b0000011: w_dec_addr = ADDR_W'(11);
      7'b0100011: w_dec_addr = ADDR_W'(12);
      7'b1100011: w_dec_addr = ADDR_W'(13);
      7'b0010011: begin
        unique case (w_f3)
          3'b000: w_dec_addr = ADDR_W'(14);
          3'b010: w_dec_addr = ADDR_W'(15);
          3'b011: w_dec_addr = ADDR_W'(16);
          3'b100: w_dec_addr = ADDR_W'(17);
          3'b110: w_dec_addr = ADDR_W'(18);
          3'b111: w_dec_addr = ADDR_W'(19);
          3'b001: if (w_f7 == 7'b0000000) w_dec_addr = ADDR_W'(20);
          default: begin
            if (w_f7 == 7'b0000000)      w_dec_addr = ADDR_W'(21);
            else if (w_f7 == 7'b0100000) w_dec_addr = ADDR_W'(22);
          end
        endcase
      end
      7'b0110111: w_dec_addr = ADDR_W'(23);
      7'b0010111: w_dec_addr = ADDR_W'(24);
      7'b1101111: w_dec_addr = ADDR_W'(25);
      7'b1100111: w_dec_addr = ADDR_W'(26);
      default:    w_dec_addr = ILLEGAL_ADDR;
    endcase
    w_dec_illegal = (w_dec_addr == ILLEGAL_ADDR);
  end

  assign in_ready  = (r_occ != OCC_W'(DEPTH));
  assign out_valid = (r_occ != '0);
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;

  // Entry storage: written at the tail on every accepted push.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr]  <= w_dec_addr;
      r_mem_instr[r_wr_ptr] <= in_instr;
      r_mem_ill[r_wr_ptr]   <= w_dec_illegal;
    end
  end

  // Queue bookkeeping: pointers and occupancy, with flush clearing everything.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_occ <= r_occ + OCC_W'(1);
      else if (w_pop && !w_push) r_occ <= r_occ - OCC_W'(1);
    end
  end

  // Saturating count of accepted illegal instructions; survives flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_push && w_dec_illegal && r_cnt != {CNT_W{1'b1}}) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_addr      = out_valid ? r_mem_addr[r_rd_ptr]  : '0;
  assign out_instr     = out_valid ? r_mem_instr[r_rd_ptr] : '0;
  assign out_illegal   = out_valid ? r_mem_ill[r_rd_ptr]   : 1'b0;
  assign occupancy     = r_occ;
  assign illegal_count = r_cnt;

endmodule

// File: tb/tb_uop_dispatch_queue.sv
// tb/tb_uop_dispatch_queue.sv - directed bench for uop_dispatch_queue
module tb_uop_dispatch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: defaults (MEXT_EN=1, DEPTH=2, CNT_W=16)
  logic        rst_a, a_in_valid, a_out_ready, a_flush;
  logic [31:0] a_in_instr;
  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [5:0]  a_out_addr;
  logic [31:0] a_out_instr;
  logic [1:0]  a_occ;
  logic [15:0] a_cnt;

  // Instances B (MEXT_EN=0) and C (CNT_W=2) share one stimulus
  logic        rst_b, b_in_valid, b_out_ready, b_flush;
  logic [31:0] b_in_instr;
  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [5:0]  b_out_addr;
  logic [31:0] b_out_instr;
  logic [1:0]  b_occ;
  logic [15:0] b_cnt;
  logic        c_in_ready, c_out_valid, c_out_illegal;
  logic [5:0]  c_out_addr;
  logic [31:0] c_out_instr;
  logic [1:0]  c_occ;
  logic [1:0]  c_cnt;

  int exp_cnt_a = 0;

  uop_dispatch_queue u_a (
    .clk(clk), .reset(rst_a), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_instr(a_in_instr), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_addr(a_out_addr), .out_instr(a_out_instr), .out_illegal(a_out_illegal),
    .flush(a_flush), .occupancy(a_occ), .illegal_count(a_cnt)
  );

  uop_dispatch_queue #(.MEXT_EN(0)) u_b (
    .clk(clk), .reset(rst_b), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instr(b_in_instr), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_addr(b_out_addr), .out_instr(b_out_instr), .out_illegal(b_out_illegal),
    .flush(b_flush), .occupancy(b_occ), .illegal_count(b_cnt)
  );

  uop_dispatch_queue #(.CNT_W(2)) u_c (
    .clk(clk), .reset(rst_b), .in_valid(b_in_valid), .in_ready(c_in_ready),
    .in_instr(b_in_instr), .out_valid(c_out_valid), .out_ready(b_out_ready),
    .out_addr(c_out_addr), .out_instr(c_out_instr), .out_illegal(c_out_illegal),
    .flush(b_flush), .occupancy(c_occ), .illegal_count(c_cnt)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%0b exp=0", a_out_valid); end
    tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%0b exp=1", a_in_ready); end
    tests++; if (a_occ !== 2'd0) begin fails++; $display("FAIL reset_occ got=%0d exp=0", a_occ); end
    tests++; if (a_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt got=%0d exp=0", a_cnt); end
    tests++; if (a_out_addr !== 6'd0 || a_out_instr !== 32'd0 || a_out_illegal !== 1'b0) begin
      fails++; $display("FAIL reset_head got=%0d/%h/%0b exp=0/0/0", a_out_addr, a_out_instr, a_out_illegal); end
    tests++; if (b_out_valid !== 1'b0 || c_cnt !== 2'd0) begin
      fails++; $display("FAIL reset_bc got=%0b/%0d exp=0/0", b_out_valid, c_cnt); end
  endtask

  task automatic test_add();
    a_in_valid = 1'b1; a_in_instr = 32'h002081B3; a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tests++; if (a_out_valid !== 1'b1) begin fails++; $display("FAIL add_valid got=%0b exp=1", a_out_valid); end
    tests++; if (a_out_addr !== 6'd1) begin fails++; $display("FAIL add_addr got=%0d exp=1", a_out_addr); end
    tests++; if (a_out_illegal !== 1'b0) begin fails++; $display("FAIL add_illegal got=%0b exp=0", a_out_illegal); end
    tests++; if (a_out_instr !== 32'h002081B3) begin fails++; $display("FAIL add_instr got=%h exp=002081b3", a_out_instr); end
    tick();
    tests++; if (a_out_valid !== 1'b0 || a_out_addr !== 6'd0 || a_occ !== 2'd0) begin
      fails++; $display("FAIL add_drain got=%0b/%0d/%0d exp=0/0/0", a_out_valid, a_out_addr, a_occ); end
  endtask

  task automatic test_mext();
    a_in_valid = 1'b1; a_in_instr = 32'h022081B3;
    b_in_valid = 1'b1; b_in_instr = 32'h022081B3;
    tick();
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    tests++; if (a_out_addr !== 6'd27 || a_out_illegal !== 1'b0) begin
      fails++; $display("FAIL mul_mext1 got=%0d/%0b exp=27/0", a_out_addr, a_out_illegal); end
    tests++; if (a_cnt !== 16'd0) begin fails++; $display("FAIL mul_mext1_cnt got=%0d exp=0", a_cnt); end
    tests++; if (b_out_addr !== 6'd63 || b_out_illegal !== 1'b1) begin
      fails++; $display("FAIL mul_mext0 got=%0d/%0b exp=63/1", b_out_addr, b_out_illegal); end
    tests++; if (b_cnt !== 16'd1) begin fails++; $display("FAIL mul_mext0_cnt got=%0d exp=1", b_cnt); end
    tests++; if (c_out_addr !== 6'd27 || c_cnt !== 2'd0) begin
      fails++; $display("FAIL mul_c got=%0d/%0d exp=27/0", c_out_addr, c_cnt); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vi [18];
    logic [5:0]  va [18];
    vi = '{32'h40000033, 32'h40001033, 32'h00000013, 32'h40005013, 32'h00001013, 32'h40001013,
           32'h00000037, 32'h0000006F, 32'h00000067, 32'h00000003, 32'h00007033, 32'h02007033,
           32'h00000000, 32'h00002033, 32'h00000017, 32'h00000063, 32'h00000023, 32'h02001033};
    va = '{6'd2, 6'd63, 6'd14, 6'd22, 6'd20, 6'd63, 6'd23, 6'd25, 6'd26, 6'd11, 6'd3, 6'd34,
           6'd63, 6'd9, 6'd24, 6'd13, 6'd12, 6'd30};
    a_out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      a_in_valid = 1'b1; a_in_instr = vi[i];
      tick();
      if (va[i] == 6'd63) exp_cnt_a++;
      tests++; if (a_out_addr !== va[i] || a_out_illegal !== (va[i] == 6'd63) || a_out_instr !== vi[i]) begin
        fails++; $display("FAIL decode[%0d] got=%0d/%0b/%h exp=%0d/%0b/%h", i, a_out_addr, a_out_illegal,
                          a_out_instr, va[i], va[i] == 6'd63, vi[i]); end
      tests++; if (a_occ !== 2'd1) begin fails++; $display("FAIL b2b_occ[%0d] got=%0d exp=1", i, a_occ); end
    end
    a_in_valid = 1'b0;
    tick();
    tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got=%0b exp=0", a_out_valid); end
    tests++; if (a_cnt !== 16'(exp_cnt_a)) begin fails++; $display("FAIL b2b_cnt got=%0d exp=%0d", a_cnt, exp_cnt_a); end
  endtask

  task automatic test_full();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_instr = 32'h002081B3;
    tick();
    tests++; if (a_occ !== 2'd1 || a_in_ready !== 1'b1) begin
      fails++; $display("FAIL full_1 got=%0d/%0b exp=1/1", a_occ, a_in_ready); end
    a_in_instr = 32'h40000033;
    tick();
    tests++; if (a_occ !== 2'd2 || a_in_ready !== 1'b0) begin
      fails++; $display("FAIL full_2 got=%0d/%0b exp=2/0", a_occ, a_in_ready); end
    tests++; if (a_out_addr !== 6'd1) begin fails++; $display("FAIL full_head got=%0d exp=1", a_out_addr); end
    a_in_instr = 32'h00000037;
    tick();
    a_in_valid = 1'b0;
    tests++; if (a_occ !== 2'd2 || a_out_addr !== 6'd1 || a_out_instr !== 32'h002081B3) begin
      fails++; $display("FAIL full_hold got=%0d/%0d/%h exp=2/1/002081b3", a_occ, a_out_addr, a_out_instr); end
    a_out_ready = 1'b1;
    tick();
    tests++; if (a_out_addr !== 6'd2 || a_out_instr !== 32'h40000033 || a_occ !== 2'd1) begin
      fails++; $display("FAIL full_pop1 got=%0d/%h/%0d exp=2/40000033/1", a_out_addr, a_out_instr, a_occ); end
    tick();
    tests++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin
      fails++; $display("FAIL full_pop2 got=%0b/%0d exp=0/0", a_out_valid, a_occ); end
    tests++; if (a_cnt !== 16'(exp_cnt_a)) begin fails++; $display("FAIL full_cnt got=%0d exp=%0d", a_cnt, exp_cnt_a); end
  endtask

  task automatic test_flush();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_instr = 32'h002081B3;
    tick();
    a_in_instr = 32'h40000033;
    tick();
    tests++; if (a_occ !== 2'd2) begin fails++; $display("FAIL flush_fill got=%0d exp=2", a_occ); end
    a_flush = 1'b1; a_in_instr = 32'hFFFFFFFF; a_out_ready = 1'b1;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    tests++; if (a_occ !== 2'd0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      fails++; $display("FAIL flush_clear got=%0d/%0b/%0b exp=0/0/1", a_occ, a_out_valid, a_in_ready); end
    tests++; if (a_cnt !== 16'(exp_cnt_a)) begin fails++; $display("FAIL flush_cnt got=%0d exp=%0d", a_cnt, exp_cnt_a); end
    a_in_valid = 1'b1; a_in_instr = 32'h00000063; a_out_ready = 1'b0;
    tick();
    a_in_valid = 1'b0;
    tests++; if (a_occ !== 2'd1 || a_out_addr !== 6'd13) begin
      fails++; $display("FAIL flush_after got=%0d/%0d exp=1/13", a_occ, a_out_addr); end
    a_out_ready = 1'b1;
    tick();
  endtask

  task automatic test_saturate();
    b_out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      b_in_valid = 1'b1; b_in_instr = 32'hFFFFFFFF;
      tick();
      tests++; if (c_cnt !== 2'((k > 3) ? 3 : k)) begin
        fails++; $display("FAIL sat_c[%0d] got=%0d exp=%0d", k, c_cnt, (k > 3) ? 3 : k); end
      tests++; if (b_cnt !== 16'(1 + k)) begin
        fails++; $display("FAIL sat_b[%0d] got=%0d exp=%0d", k, b_cnt, 1 + k); end
    end
    b_in_valid = 1'b0;
    tick();
    tests++; if (c_out_valid !== 1'b0 || c_out_illegal !== 1'b0) begin
      fails++; $display("FAIL sat_drain got=%0b/%0b exp=0/0", c_out_valid, c_out_illegal); end
  endtask

  task automatic test_reset_mid();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_instr = 32'hFFFFFFFF;
    tick();
    a_in_instr = 32'h002081B3;
    tick();
    exp_cnt_a++;
    tests++; if (a_occ !== 2'd2 || a_cnt !== 16'(exp_cnt_a)) begin
      fails++; $display("FAIL rmid_fill got=%0d/%0d exp=2/%0d", a_occ, a_cnt, exp_cnt_a); end
    rst_a = 1'b1; a_out_ready = 1'b1;
    tick();
    rst_a = 1'b0; a_in_valid = 1'b0;
    tests++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_in_ready !== 1'b1 || a_cnt !== 16'd0) begin
      fails++; $display("FAIL rmid_state got=%0b/%0d/%0b/%0d exp=0/0/1/0", a_out_valid, a_occ, a_in_ready, a_cnt); end
    tests++; if (a_out_addr !== 6'd0 || a_out_instr !== 32'd0) begin
      fails++; $display("FAIL rmid_head got=%0d/%h exp=0/0", a_out_addr, a_out_instr); end
  endtask

  initial begin
    rst_a = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b0; a_flush = 1'b0; a_in_instr = '0;
    rst_b = 1'b1; b_in_valid = 1'b0; b_out_ready = 1'b1; b_flush = 1'b0; b_in_instr = '0;
    tick();
    tick();
    rst_a = 1'b0; rst_b = 1'b0;
    test_reset();
    test_add();
    test_mext();
    test_back_to_back();
    test_full();
    test_flush();
    test_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
